// File: rtl/pmu_pkg.sv
// Shared constants and types for the Lagarto PMU controller: register map,
// access FSM states and the CTRL freeze bit position.
package pmu_pkg;

  // Register map (6-bit address space)
  localparam logic [5:0] PMU_CNT_BASE = 6'h00;
  localparam logic [5:0] PMU_SEL_BASE = 6'h10;
  localparam logic [5:0] PMU_CTRL     = 6'h20;
  localparam logic [5:0] PMU_OVF      = 6'h21;
  localparam logic [5:0] PMU_MASK     = 6'h22;

  // CTRL bit that stops every counter regardless of its enable
  localparam int PMU_FREEZE_BIT = 63;

  // Width of an event selector field
  localparam int PMU_SEL_WIDTH = 5;

  // Register access FSM: accept a request, then hold the response
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } pmu_fsm_e;

endpackage

// File: rtl/lagarto_pmu_counter.sv
// One programmable PMU counter. Software writes take priority over a
// same-cycle increment, and an increment from all-ones wraps to zero while
// raising a single-cycle overflow pulse.
module lagarto_pmu_counter
  import pmu_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  input  logic                 we_i,
  input  logic [CNT_WIDTH-1:0] wdata_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 ovf_o
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Write beats increment; overflow only reported for a real wrap-around
  always_comb begin
    count_d = count_q;
    ovf_o   = 1'b0;
    if (we_i) begin
      count_d = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + CNT_WIDTH'(1);
      ovf_o   = &count_q;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lagarto_pmu_ctrl.sv
// Lagarto tile performance-monitor controller. Registers the event vector,
// routes selected events to a bank of counters and serves a
// single-outstanding register request/response port.
// Optional feature macro: LAGARTO_PMU_OVF_IRQ_EN enables the OVF status and
// MASK registers and a functional irq_o; without it those addresses read 0
// and irq_o stays low.
module lagarto_pmu_ctrl
  import pmu_pkg::*;
#(
  parameter int NUM_EVENTS   = 25,
  parameter int NUM_COUNTERS = 8,
  parameter int CNT_WIDTH    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_EVENTS-1:0] pmu_sig_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [5:0]            req_addr_i,
  input  logic [63:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [63:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  irq_o
);

  logic [NUM_EVENTS-1:0]    sig_q;
  logic [PMU_SEL_WIDTH-1:0] sel_q [NUM_COUNTERS];
  logic [PMU_SEL_WIDTH-1:0] sel_d [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  enable_q, enable_d;
  logic                     freeze_q, freeze_d;

  pmu_fsm_e    state_q, state_d;
  logic [63:0] rspData_q, rspData_d;
  logic        rspErr_q, rspErr_d;

  logic [CNT_WIDTH-1:0]    cntVal [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] cntWe;
  logic [NUM_COUNTERS-1:0] cntInc;
  logic [NUM_COUNTERS-1:0] evHit;
  logic [NUM_COUNTERS-1:0] ovfPulse;

  logic        reqFire;
  logic        regWe;
  logic [3:0]  addrIdx;
  logic        idxOk;
  logic        isCnt, isSel, isCtrl, isOvf, isMask;
  logic [63:0] cntRead, selRead, ctrlRead, ovfRead, maskRead;
  logic [63:0] rdData;
  logic        decErr;

  assign reqFire = req_valid_i && req_ready_o;
  assign regWe   = reqFire && req_we_i;
  assign addrIdx = req_addr_i[3:0];
  assign idxOk   = int'(addrIdx) < NUM_COUNTERS;
  assign isCnt   = (req_addr_i[5:4] == PMU_CNT_BASE[5:4]) && idxOk;
  assign isSel   = (req_addr_i[5:4] == PMU_SEL_BASE[5:4]) && idxOk;
  assign isCtrl  = (req_addr_i == PMU_CTRL);
  assign isOvf   = (req_addr_i == PMU_OVF);
  assign isMask  = (req_addr_i == PMU_MASK);

  // Event vector is registered once so counting sees a clean copy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= '0;
    end else begin
      sig_q <= pmu_sig_i;
    end
  end

  // Pick each counter's event; out-of-range selectors never match
  always_comb begin
    evHit = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if (sel_q[i] == PMU_SEL_WIDTH'(e)) begin
          evHit[i] = sig_q[e];
        end
      end
      cntInc[i] = enable_q[i] && !freeze_q && evHit[i];
      cntWe[i]  = regWe && isCnt && (addrIdx == 4'(i));
    end
  end

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : gen_cnt
    lagarto_pmu_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (cntInc[g]),
      .we_i   (cntWe[g]),
      .wdata_i(req_wdata_i[CNT_WIDTH-1:0]),
      .count_o(cntVal[g]),
      .ovf_o  (ovfPulse[g])
    );
  end

  // Software updates of selectors and CTRL; they take effect next cycle
  always_comb begin
    enable_d = enable_q;
    freeze_d = freeze_q;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      sel_d[i] = sel_q[i];
      if (regWe && isSel && (addrIdx == 4'(i))) begin
        sel_d[i] = req_wdata_i[PMU_SEL_WIDTH-1:0];
      end
    end
    if (regWe && isCtrl) begin
      enable_d = req_wdata_i[NUM_COUNTERS-1:0];
      freeze_d = req_wdata_i[PMU_FREEZE_BIT];
    end
  end

  // Selector and CTRL registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q <= '0;
      freeze_q <= 1'b0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        sel_q[i] <= '0;
      end
    end else begin
      enable_q <= enable_d;
      freeze_q <= freeze_d;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        sel_q[i] <= sel_d[i];
      end
    end
  end

`ifdef LAGARTO_PMU_OVF_IRQ_EN
  logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;
  logic [NUM_COUNTERS-1:0] mask_q, mask_d;
  logic [NUM_COUNTERS-1:0] ovfClr;
  logic                    irq_q;

  // W1C clears first, so a same-cycle overflow still leaves the bit set
  always_comb begin
    ovfClr = (regWe && isOvf) ? req_wdata_i[NUM_COUNTERS-1:0] : '0;
    ovf_d  = (ovf_q & ~ovfClr) | ovfPulse;
    mask_d = (regWe && isMask) ? req_wdata_i[NUM_COUNTERS-1:0] : mask_q;
  end

  // Overflow status, mask and the registered interrupt level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q  <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      mask_q <= mask_d;
      irq_q  <= |(ovf_q & mask_q);
    end
  end

  // Zero-extended views of the overflow registers for the read mux
  always_comb begin
    ovfRead                   = '0;
    maskRead                  = '0;
    ovfRead[NUM_COUNTERS-1:0]  = ovf_q;
    maskRead[NUM_COUNTERS-1:0] = mask_q;
  end

  assign irq_o = irq_q;
`else
  logic unusedOvf;

  assign unusedOvf = ^ovfPulse;
  assign ovfRead   = '0;
  assign maskRead  = '0;
  assign irq_o     = 1'b0;
`endif

  // Indexed read views: counter value before this cycle's increment
  always_comb begin
    cntRead  = '0;
    selRead  = '0;
    ctrlRead = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (addrIdx == 4'(i)) begin
        cntRead[CNT_WIDTH-1:0]     = cntVal[i];
        selRead[PMU_SEL_WIDTH-1:0] = sel_q[i];
      end
    end
    ctrlRead[NUM_COUNTERS-1:0] = enable_q;
    ctrlRead[PMU_FREEZE_BIT]   = freeze_q;
  end

  // Address decode into read data and the unmapped-address flag
  always_comb begin
    rdData = '0;
    decErr = 1'b0;
    if (isCnt) begin
      rdData = cntRead;
    end else if (isSel) begin
      rdData = selRead;
    end else if (isCtrl) begin
      rdData = ctrlRead;
    end else if (isOvf) begin
      rdData = ovfRead;
    end else if (isMask) begin
      rdData = maskRead;
    end else begin
      decErr = 1'b1;
    end
  end

  // Access FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Access FSM next state: one accepted request, then wait for consume
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access FSM outputs
  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
  end

  // Capture response at acceptance so it stays stable under backpressure
  always_comb begin
    rspData_d = rspData_q;
    rspErr_d  = rspErr_q;
    if (reqFire) begin
      rspData_d = req_we_i ? 64'd0 : rdData;
      rspErr_d  = decErr;
    end
  end

  // Response registers; reset drops any pending response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rspData_q <= '0;
      rspErr_q  <= 1'b0;
    end else begin
      rspData_q <= rspData_d;
      rspErr_q  <= rspErr_d;
    end
  end

  assign rsp_rdata_o = rspData_q;
  assign rsp_err_o   = rspErr_q;

endmodule

// File: tb/tb_lagarto_pmu_ctrl.sv
// Scoreboard bench for lagarto_pmu_ctrl. Requests push their expected
// response into a queue; a monitor pops and compares whenever a response
// is consumed. Expectations follow LAGARTO_PMU_OVF_IRQ_EN when defined.
module tb_lagarto_pmu_ctrl;

  localparam int NE = 25;
  localparam int NC = 8;
`ifdef LAGARTO_PMU_OVF_IRQ_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic [NE-1:0] pmu_sig_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [5:0]    req_addr_i;
  logic [63:0]   req_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [63:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          irq_o;

  typedef struct {
    logic [63:0] data;
    logic        err;
    string       name;
  } rsp_t;

  rsp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   lastHs = 0;
  int   ctrlHs = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  lagarto_pmu_ctrl #(
    .NUM_EVENTS(NE),
    .NUM_COUNTERS(NC),
    .CNT_WIDTH(64)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .pmu_sig_i  (pmu_sig_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i   (req_we_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .irq_o      (irq_o)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  task automatic pushExp(input logic [63:0] data, input logic err, input string name);
    rsp_t item;
    item.data = data;
    item.err  = err;
    item.name = name;
    expQ.push_back(item);
  endtask

  // Called at a negedge; returns at a negedge once the FSM is idle again
  task automatic applyStimulus(input logic we, input logic [5:0] addr,
                               input logic [63:0] wdata, input logic [63:0] expData,
                               input logic expErr, input string name);
    int waitCnt;
    waitCnt = 0;
    while (!req_ready_o && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready_o) begin
      failNow({name, "_ready"});
      return;
    end
    pushExp(expData, expErr, name);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    lastHs      = cyc + 1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_wdata_i = '0;
    @(negedge clk);
    waitCnt = 0;
    while (!req_ready_o && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready_o) failNow({name, "_rsp"});
  endtask

  task automatic wrReg(input logic [5:0] addr, input logic [63:0] data, input string name);
    applyStimulus(1'b1, addr, data, 64'd0, 1'b0, name);
  endtask

  task automatic rdReg(input logic [5:0] addr, input logic [63:0] exp, input string name);
    applyStimulus(1'b0, addr, 64'd0, exp, 1'b0, name);
  endtask

  // Monitor: compare each consumed response against the scoreboard head
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_i && rsp_valid_o && rsp_ready_i) begin
        if (expQ.size() == 0) begin
          failNow("unexpectedRsp");
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, "_data"}, rsp_rdata_o, e.data);
          checkOutput({e.name, "_err"}, 64'(rsp_err_o), 64'(e.err));
        end
      end
    end
  end

  // Watchdog against a hung run
  initial begin
    #1000000;
    failNow("watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i       = 1'b1;
    pmu_sig_i   = NE'(1);
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    $display("[TB] reset state");
    checkOutput("rstReqReady", 64'(req_ready_o), 64'd1);
    checkOutput("rstRspValid", 64'(rsp_valid_o), 64'd0);
    checkOutput("rstRdata", rsp_rdata_o, 64'd0);
    checkOutput("rstErr", 64'(rsp_err_o), 64'd0);
    checkOutput("rstIrq", 64'(irq_o), 64'd0);
    rdReg(6'h00, 64'd0, "cnt0Reset");

    $display("[TB] cycle counting");
    wrReg(6'h10, 64'd0, "wrSel0");
    wrReg(6'h20, 64'h1, "wrCtrl1");
    ctrlHs = lastHs;
    repeat (100) @(negedge clk);
    rdReg(6'h00, 64'(cyc + 1 - ctrlHs - 1), "cycleCount");

    $display("[TB] event select");
    wrReg(6'h13, 64'hFFFF_FFE5, "wrSel3");
    rdReg(6'h13, 64'd5, "rdSel3");
    wrReg(6'h15, 64'd31, "wrSel5");
    wrReg(6'h16, 64'd4, "wrSel6");
    wrReg(6'h20, 64'h68, "wrCtrl68");
    for (int i = 0; i < 10; i++) begin
      pmu_sig_i[4] = 1'b1;
      pmu_sig_i[5] = (i < 7);
      @(negedge clk);
    end
    pmu_sig_i[5:4] = 2'b00;
    repeat (3) @(negedge clk);
    rdReg(6'h03, 64'd7, "cnt3Ev5");
    rdReg(6'h05, 64'd0, "cnt5SelOOR");
    rdReg(6'h06, 64'd10, "cnt6Ev4");

    $display("[TB] overflow");
    wrReg(6'h12, 64'd7, "wrSel2");
    wrReg(6'h02, 64'hFFFF_FFFF_FFFF_FFFE, "wrCnt2");
    wrReg(6'h22, 64'h4, "wrMask");
    wrReg(6'h20, 64'h4, "wrCtrl4");
    pmu_sig_i[7] = 1'b1;
    repeat (2) @(negedge clk);
    pmu_sig_i[7] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("irqSet", 64'(irq_o), OVF_ON ? 64'd1 : 64'd0);
    rdReg(6'h02, 64'd0, "cnt2Wrap");
    rdReg(6'h21, OVF_ON ? 64'h4 : 64'd0, "ovfSet");
    rdReg(6'h22, OVF_ON ? 64'h4 : 64'd0, "maskRd");
    wrReg(6'h21, 64'h4, "ovfW1c");
    checkOutput("irqClear", 64'(irq_o), 64'd0);
    rdReg(6'h21, 64'd0, "ovfCleared");

    $display("[TB] collisions");
    wrReg(6'h11, 64'd9, "wrSel1");
    wrReg(6'h12, 64'd10, "wrSel2b");
    wrReg(6'h20, 64'h6, "wrCtrl6");
    wrReg(6'h02, 64'hFFFF_FFFF_FFFF_FFFF, "wrCnt2Max");
    pmu_sig_i[9] = 1'b1;
    @(negedge clk);
    pmu_sig_i[9] = 1'b0;
    wrReg(6'h01, 64'h10, "wrCnt1Collide");
    repeat (3) @(negedge clk);
    rdReg(6'h01, 64'h10, "cnt1WriteWins");
    pmu_sig_i[9] = 1'b1;
    @(negedge clk);
    pmu_sig_i[9] = 1'b0;
    repeat (3) @(negedge clk);
    rdReg(6'h01, 64'h11, "cnt1Inc");
    pmu_sig_i[10] = 1'b1;
    @(negedge clk);
    pmu_sig_i[10] = 1'b0;
    wrReg(6'h21, 64'h4, "ovfW1cCollide");
    repeat (2) @(negedge clk);
    rdReg(6'h21, OVF_ON ? 64'h4 : 64'd0, "ovfSetWins");
    rdReg(6'h02, 64'd0, "cnt2Wrap2");
    checkOutput("irqAfterCollide", 64'(irq_o), OVF_ON ? 64'd1 : 64'd0);
    wrReg(6'h21, 64'h4, "ovfW1c2");

    $display("[TB] freeze");
    wrReg(6'h04, 64'h1234, "wrCnt4");
    wrReg(6'h20, 64'h8000_0000_0000_00FF, "wrCtrlFreeze");
    rdReg(6'h20, 64'h8000_0000_0000_00FF, "rdCtrl");
    pmu_sig_i = '1;
    repeat (20) @(negedge clk);
    pmu_sig_i = NE'(1);
    repeat (3) @(negedge clk);
    rdReg(6'h04, 64'h1234, "cnt4Frozen");
    rdReg(6'h01, 64'h11, "cnt1Frozen");

    $display("[TB] backpressure");
    rsp_ready_i = 1'b0;
    pushExp(64'h1234, 1'b0, "bpRead");
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 6'h04;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bpValid", 64'(rsp_valid_o), 64'd1);
      checkOutput("bpHold", rsp_rdata_o, 64'h1234);
      checkOutput("bpReqReady", 64'(req_ready_o), 64'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bpReleased", 64'(rsp_valid_o), 64'd0);

    $display("[TB] errors");
    applyStimulus(1'b0, 6'h3F, 64'd0, 64'd0, 1'b1, "rd3F");
    applyStimulus(1'b0, 6'h18, 64'd0, 64'd0, 1'b1, "rdSel8");
    applyStimulus(1'b0, 6'h08, 64'd0, 64'd0, 1'b1, "rdCnt8");
    applyStimulus(1'b1, 6'h23, 64'hFF, 64'd0, 1'b1, "wr23");

    $display("[TB] reset during response");
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 6'h04;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("preRstValid", 64'(rsp_valid_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    checkOutput("midRstValid", 64'(rsp_valid_o), 64'd0);
    checkOutput("midRstReady", 64'(req_ready_o), 64'd1);
    checkOutput("midRstRdata", rsp_rdata_o, 64'd0);
    checkOutput("midRstIrq", 64'(irq_o), 64'd0);
    rst_i       = 1'b0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < NC; i++) begin
      rdReg(6'(i), 64'd0, $sformatf("rstCnt%0d", i));
      rdReg(6'h10 + 6'(i), 64'd0, $sformatf("rstSel%0d", i));
    end
    rdReg(6'h20, 64'd0, "rstCtrl");
    rdReg(6'h21, 64'd0, "rstOvf");
    rdReg(6'h22, 64'd0, "rstMask");

    repeat (5) @(negedge clk);
    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lagarto_pmu_ctrl.md
# lagarto_pmu_ctrl

Performance-monitor controller for the Lagarto tile. It sits beside the core wrapper and consumes the 25-bit PMU event vector, where bit 0 is tied high for cycle counting. It maps events onto a bank of programmable counters and exposes them through a single-outstanding register request/response port with optional overflow interrupt. It sequences counter enable, freeze, event selection and software access so that software reads and writes never race hardware increments.

## Interface
- NUM_EVENTS, 25, width of the event vector.
- NUM_COUNTERS, 8, number of programmable counters (1..16).
- CNT_WIDTH, 64, counter width in bits (must be ≤ 64).

- clk_i  in  1  core clock, single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- pmu_sig_i  in  NUM_EVENTS  event pulses; one increment per high cycle.
- req_valid_i  in  1  register request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  6  register address.
- req_wdata_i  in  64  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  64  read data; 0 for writes and unmapped addresses.
- rsp_err_o  out  1  unmapped address.
- irq_o  out  1  level overflow interrupt.

## Operation
- Address map:
  - 0x00+i: counter i value.
  - 0x10+i: event selector i, 5 bits, upper bits read 0.
  - 0x20: CTRL. Bits [NUM_COUNTERS-1:0] are per-counter enable. Bit 63 is global freeze.
  - 0x21: OVF status, write-1-to-clear.
  - 0x22: OVF interrupt mask.
  - Everything else is unmapped.
- Event path: pmu_sig_i is registered once into sig_q. Counter i increments when all of the following hold: enable[i], !freeze, and sig_q[sel[i]].
- A selector value ≥ NUM_EVENTS counts nothing.
- Arithmetic: counters are modulo 2^CNT_WIDTH. On increment from all-ones, the counter goes to 0 and OVF[i] is set.
- Write data is truncated to CNT_WIDTH. Reads zero-extend to 64 bits.
- Access FSM has two states, IDLE and RESP.
  - IDLE: req_ready_o=1. A handshake performs the read/write in that cycle and moves to RESP.
  - RESP: rsp_valid_o=1 and req_ready_o=0. rsp_rdata_o/rsp_err_o are held stable. rsp_valid&rsp_ready returns to IDLE.
- Simultaneous events:
  - A software write to counter i in the same cycle as an increment: the write wins and the increment is dropped.
  - A W1C of OVF[i] in the same cycle as a new overflow of counter i: the set wins.
- Read data is the counter value before that cycle's increment.
- irq_o = |(OVF & MASK), driven as a registered output.
- Reset mid-transaction: FSM returns to IDLE and any pending response is discarded.

## Timing
- Reset values:
  - All counters, selectors, CTRL, OVF and MASK are 0.
  - sig_q is 0.
  - req_ready_o=1 (from the first cycle after reset).
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, irq_o=0.
- An event high at cycle t is visible in the counter at t+2.
- Request accepted at t gives rsp_valid_o at t+1. Back-to-back throughput is one request per 2 cycles when rsp_ready_i is held high.
- A write to CTRL/selectors at t governs increments from t+1.
- A counter overflow at cycle t sets OVF at t+1 and irq_o at t+2.

## Configuration
- LAGARTO_PMU_OVF_IRQ_EN defined: OVF and MASK registers are implemented and irq_o is functional.
- LAGARTO_PMU_OVF_IRQ_EN undefined:
  - OVF and MASK are absent; 0x21/0x22 read 0, ignore writes and report no error.
  - irq_o is tied 0.
  - Counters still wrap silently.

## Structure
- pmu_pkg holds:
  - Address constants PMU_CNT_BASE, PMU_SEL_BASE, PMU_CTRL, PMU_OVF, PMU_MASK.
  - Typedef pmu_fsm_e {IDLE, RESP}.
  - Constant PMU_FREEZE_BIT=63.
- One sub-module, lagarto_pmu_counter, instantiated NUM_COUNTERS times. It holds the count register, the increment/write priority and the overflow pulse. The top level keeps selectors, CTRL, OVF/MASK and the FSM.

## Test plan
- Cycle counting: after reset, write sel0=0 and CTRL=0x1. Hold for 100 cycles, then read 0x00 → value equals cycles elapsed since CTRL write minus 1, within ±0 of model.
- Event select: set sel3=5 and CTRL=0x8. Pulse pmu_sig_i[5] 7 times and bit 4 10 times. Read 0x03 → 7.
- Overflow/IRQ (macro on): write counter2=0xFFFF_FFFF_FFFF_FFFE, MASK=0x4, CTRL=0x4, then send 2 events. Expected: counter2=0, OVF=0x4, irq_o=1. Write 0x4 to OVF → irq_o=0 two cycles later.
- Collision: write counter1=0x10 in the same cycle as an increment → read 0x10. Also set OVF and W1C it in the same cycle → OVF stays set.
- Freeze and backpressure: set CTRL bit63 with enables on, and drive events → counters are unchanged. Issue a read with rsp_ready_i low for 5 cycles → rsp_valid_o and data stay stable, and req_ready_o=0 throughout.
- Errors and reset: read 0x3F → rsp_err_o=1, data 0. Assert rst_i during RESP → next cycle rsp_valid_o=0 and all registers read 0.
